// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES constants, FSM encoding and round helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int AES_NR_256 = 14;
    localparam int AES_NR_192 = 12;
    localparam int AES_NR_128 = 10;

    typedef logic [2:0] state_t;

    localparam state_t c_IDLE  = 3'd0;
    localparam state_t c_ADD0  = 3'd1;
    localparam state_t c_ROUND = 3'd2;
    localparam state_t c_FINAL = 3'd3;
    localparam state_t c_DONE  = 3'd4;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte k = 4*col + row sits at [127-8k -: 8]; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes256_enc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : aes256_enc_ctrl_if
// Description : Block in/out handshakes plus the shared sub_bytes data path.
// Revision    : 1.0 - initial release
// ============================================================================
interface aes256_enc_ctrl_if;

    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic [127:0] sb_in;
    logic [127:0] sb_out;

    modport master (
        input  in_valid, in_block, out_ready, sb_out,
        output in_ready, out_valid, out_block, sb_in
    );

    modport slave (
        output in_valid, in_block, out_ready, sb_out,
        input  in_ready, out_valid, out_block, sb_in
    );

endinterface
`default_nettype wire

// File: rtl/aes_mix_columns.sv
`default_nettype none
// ============================================================================
// Module      : aes_mix_columns
// Description : Combinational AES MixColumns over four independent columns.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_mix_columns
    import aes_pkg::*;
(
    input  wire [127:0] i_state,
    output logic [127:0] o_state
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] w_a0, w_a1, w_a2, w_a3;

        assign {w_a0, w_a1, w_a2, w_a3} = i_state[127 - 32*c -: 32];

        assign o_state[127 - 32*c -: 32] = {
            xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3,
            w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3,
            w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3,
            xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3)
        };
    end

endmodule
`default_nettype wire

// File: rtl/aes256_enc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes256_enc_ctrl
// Description : Iterative AES round sequencer, one round per cycle, shared S-box.
// Revision    : 1.0 - initial release
// ============================================================================
module aes256_enc_ctrl
    import aes_pkg::*;
#(
    parameter int NR    = AES_NR_256,
    parameter int RK_AW = 4
) (
    input  wire               clk,
    input  wire               rst_n,
    input  wire               key_ready,
    aes256_enc_ctrl_if.master bus,
    output logic              rk_req,
    output logic [RK_AW-1:0]  rk_addr,
    input  wire [127:0]       rk_data,
    output logic              busy,
    output logic [RK_AW-1:0]  round_o
);

    localparam logic [RK_AW-1:0] c_LAST_ROUND = RK_AW'(NR - 1);
    localparam logic [RK_AW-1:0] c_ONE        = RK_AW'(1);

    state_t           r_state;
    state_t           w_next;
    logic [127:0]     r_st;
    logic [127:0]     r_out_block;
    logic [RK_AW-1:0] r_round;
    logic             w_in_ready;
    logic             w_accept;
    logic [127:0]     w_sr;
    logic [127:0]     w_mix;
    logic [127:0]     w_final;

    // Gating with rst_n keeps any handshake from completing while in reset.
    assign w_in_ready = (r_state == c_IDLE) & key_ready & rst_n;
    assign w_accept   = bus.in_valid & w_in_ready;

    assign w_sr    = shift_rows(bus.sb_out);
    assign w_final = w_sr ^ rk_data;

    aes_mix_columns u_mix (
        .i_state (w_sr),
        .o_state (w_mix)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_next = c_ADD0;
            c_ADD0:  w_next = c_ROUND;
            c_ROUND: if (r_round == c_LAST_ROUND) w_next = c_FINAL;
            c_FINAL: w_next = c_DONE;
            c_DONE:  if (bus.out_ready) w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // The key for the next cycle's operation is requested one cycle ahead.
    always_comb begin
        rk_req        = 1'b0;
        rk_addr       = '0;
        bus.out_valid = 1'b0;
        busy          = (r_state != c_IDLE);
        case (r_state)
            c_IDLE:  rk_req = w_accept;
            c_ADD0: begin
                rk_req  = 1'b1;
                rk_addr = c_ONE;
            end
            c_ROUND: begin
                rk_req  = 1'b1;
                rk_addr = r_round + c_ONE;
            end
            c_DONE:  bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st        <= '0;
            r_round     <= '0;
            r_out_block <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_st    <= bus.in_block;
                        r_round <= '0;
                    end
                end
                c_ADD0: begin
                    r_st    <= r_st ^ rk_data;
                    r_round <= c_ONE;
                end
                c_ROUND: begin
                    r_st    <= w_mix ^ rk_data;
                    r_round <= r_round + c_ONE;
                end
                c_FINAL: begin
                    r_st        <= w_final;
                    r_out_block <= w_final;
                end
                c_DONE: begin
                    if (bus.out_ready) r_round <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.sb_in     = r_st;
    assign bus.out_block = r_out_block;
    assign round_o       = r_round;

endmodule
`default_nettype wire

// File: tb/tb_aes256_enc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes256_enc_ctrl
// Description : Directed bench for aes256_enc_ctrl with S-box and key-store models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes256_enc_ctrl;

    localparam int NR    = 14;
    localparam int RK_AW = 4;

    localparam logic [255:0] c_KEY   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] c_C3_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             key_ready;
    logic             rk_req;
    logic [RK_AW-1:0] rk_addr;
    logic [127:0]     rk_data;
    logic             busy;
    logic [RK_AW-1:0] round_o;

    aes256_enc_ctrl_if bus ();

    aes256_enc_ctrl #(.NR(NR), .RK_AW(RK_AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_ready (key_ready),
        .bus       (bus.master),
        .rk_req    (rk_req),
        .rk_addr   (rk_addr),
        .rk_data   (rk_data),
        .busy      (busy),
        .round_o   (round_o)
    );

    always #5 clk = ~clk;

    // ---------------- GF(2^8) reference arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: x^254 inverse then the affine map.
    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        logic [7:0] inv, base, b;
        logic [7:0] e;
        inv = 8'h01; base = x; e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) inv = gmul(inv, base);
            base = gmul(base, base);
        end
        b = inv;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes_f(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++) o[127 - 8*k -: 8] = sbox_f(s[127 - 8*k -: 8]);
        return o;
    endfunction

    assign bus.sb_out = sub_bytes_f(bus.sb_in);

    logic [127:0] rk_tab [16];

    task automatic expand_key(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        rcon = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_f(t[31:24]), sbox_f(t[23:16]), sbox_f(t[15:8]), sbox_f(t[7:0])};
                t = t ^ {rcon, 24'h000000};
                rcon = gmul(rcon, 8'h02);
            end else if (i % 8 == 4) begin
                t = {sbox_f(t[31:24]), sbox_f(t[23:16]), sbox_f(t[15:8]), sbox_f(t[7:0])};
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        rk_tab[15] = '0;
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int k = 0; k < 16; k++) s[k] = pt[127 - 8*k -: 8] ^ rk_tab[0][127 - 8*k -: 8];
        for (int r = 1; r <= NR; r++) begin
            for (int k = 0; k < 16; k++) s[k] = sbox_f(s[k]);
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4*c + row] = s[4*((c + row) % 4) + row];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r != NR) begin
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk_tab[r][127 - 8*k -: 8];
        end
        res = '0;
        for (int k = 0; k < 16; k++) res[127 - 8*k -: 8] = s[k];
        return res;
    endfunction

    // Key store: data valid one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        if (rk_req) rk_data <= rk_tab[rk_addr];
        else        rk_data <= 128'h5a5a_a5a5_5a5a_a5a5_5a5a_a5a5_5a5a_a5a5;
    end

    // ---------------- event monitor ----------------
    int           cyc = 0;
    int           acc_q [$];
    int           hs_q [$];
    logic [127:0] ct_q [$];
    int           rk_a_q [$];
    int           rk_c_q [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
            if (bus.out_valid && bus.out_ready) begin
                hs_q.push_back(cyc);
                ct_q.push_back(bus.out_block);
            end
            if (rk_req) begin
                rk_a_q.push_back(int'(rk_addr));
                rk_c_q.push_back(cyc);
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_blk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        acc_q.delete();
        rk_a_q.delete();
        rk_c_q.delete();
    endtask

    // Entered one time unit after the accepting edge.
    task automatic finish_block(input logic [127:0] exp, input int stall, input logic drop_key,
                                input string name);
        int n, err, hs0, acc;
        hs0 = hs_q.size();
        acc = (acc_q.size() > 0) ? acc_q[acc_q.size()-1] : -1;
        bus.in_valid = 1'b0;
        if (drop_key) key_ready = 1'b0;
        check_bit({name, " busy_after_accept"}, busy, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
        end
        check_int({name, " latency"}, n, NR + 1);
        check_blk({name, " out_block"}, bus.out_block, exp);
        err = 0;
        for (int i = 0; i < stall; i++) begin
            if (!bus.out_valid || bus.out_block !== exp || bus.in_ready || !busy) err++;
            tick();
        end
        if (stall > 0) check_int({name, " stall_stable_errs"}, err, 0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_bit({name, " valid_drop"}, bus.out_valid, 1'b0);
        check_int({name, " handshakes"}, hs_q.size() - hs0, 1);
        err = 0;
        if (rk_a_q.size() != NR + 1) err++;
        else
            for (int i = 0; i <= NR; i++)
                if (rk_a_q[i] != i || rk_c_q[i] != acc + i) err++;
        check_int({name, " rk_seq_errs"}, err, 0);
        key_ready = 1'b1;
    endtask

    task automatic run_block(input logic [127:0] pt, input logic [127:0] exp, input int stall,
                             input logic drop_key, input string name);
        int k;
        clear_mon();
        bus.in_block  = pt;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        #1;
        k = 0;
        while (!bus.in_ready && k < 50) begin
            tick();
            k++;
        end
        if (!bus.in_ready) begin
            check_bit({name, " accept_timeout"}, bus.in_ready, 1'b1);
            bus.in_valid = 1'b0;
        end else begin
            tick();
            finish_block(exp, stall, drop_key, name);
        end
    endtask

    typedef struct {
        logic [127:0] pt;
        logic [127:0] ct;
        int           stall;
        logic         drop_key;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   err, k, hs0, a0, a1, h0;
        logic any;

        rst_n         = 1'b1;
        key_ready     = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_block  = c_C3_PT;
        bus.out_ready = 1'b1;
        expand_key(c_KEY);

        vecs[0] = '{c_C3_PT, c_C3_CT, 0, 1'b0};
        vecs[1] = '{128'h0, ref_encrypt(128'h0), 20, 1'b0};
        vecs[2] = '{{128{1'b1}}, ref_encrypt({128{1'b1}}), 3, 1'b1};
        vecs[3] = '{128'h0123456789abcdeffedcba9876543210,
                    ref_encrypt(128'h0123456789abcdeffedcba9876543210), 1, 1'b0};

        // Reset with valid traffic pending: nothing may handshake.
        #2 rst_n = 1'b0;
        err = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.in_ready || rk_req || busy || bus.out_valid) err++;
        end
        check_int("reset_no_handshake_errs", err, 0);
        check_blk("reset_out_block", bus.out_block, 128'h0);
        check_int("reset_rk_addr", int'(rk_addr), 0);
        check_int("reset_round_o", int'(round_o), 0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b1;
        tick();

        // key_ready gates acceptance.
        clear_mon();
        key_ready    = 1'b0;
        bus.in_block = c_C3_PT;
        bus.in_valid = 1'b1;
        err = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.in_ready || rk_req || busy) err++;
        end
        check_int("keygate_blocked_errs", err, 0);
        key_ready = 1'b1;
        #1;
        check_bit("keygate_in_ready", bus.in_ready, 1'b1);
        check_bit("keygate_rk_req", rk_req, 1'b1);
        check_int("keygate_rk_addr", int'(rk_addr), 0);
        tick();
        finish_block(c_C3_CT, 0, 1'b0, "keygate_c3");

        for (int i = 0; i < 4; i++)
            run_block(vecs[i].pt, vecs[i].ct, vecs[i].stall, vecs[i].drop_key, $sformatf("vec%0d", i));

        // Back-to-back: input held valid; the second block must not leak in while busy.
        tick();
        clear_mon();
        hs0           = hs_q.size();
        bus.out_ready = 1'b1;
        bus.in_block  = c_C3_PT;
        bus.in_valid  = 1'b1;
        k = 0;
        while (acc_q.size() < 1 && k < 50) begin tick(); k++; end
        bus.in_block = 128'h0;
        k = 0;
        while (acc_q.size() < 2 && k < 60) begin tick(); k++; end
        bus.in_valid = 1'b0;
        k = 0;
        while (hs_q.size() < hs0 + 2 && k < 40) begin tick(); k++; end
        bus.out_ready = 1'b0;
        check_int("b2b_accepts", acc_q.size(), 2);
        check_int("b2b_handshakes", hs_q.size() - hs0, 2);
        check_blk("b2b_ct0", (ct_q.size() > hs0) ? ct_q[hs0] : 128'hx, c_C3_CT);
        check_blk("b2b_ct1", (ct_q.size() > hs0 + 1) ? ct_q[hs0+1] : 128'hx, ref_encrypt(128'h0));
        a0 = (acc_q.size() > 0) ? acc_q[0] : -100;
        a1 = (acc_q.size() > 1) ? acc_q[1] : -100;
        h0 = (hs_q.size() > hs0) ? hs_q[hs0] : -100;
        check_int("b2b_accept_after_hs", a1 - h0, 1);
        check_int("b2b_spacing", a1 - a0, NR + 3);
        err = 0;
        if (rk_a_q.size() != 2*(NR + 1)) err++;
        else
            for (int i = 0; i < 2*(NR + 1); i++)
                if (rk_a_q[i] != i % (NR + 1) || rk_c_q[i] != ((i <= NR) ? a0 : a1) + i % (NR + 1)) err++;
        check_int("b2b_rk_seq_errs", err, 0);

        // Asynchronous reset during round 7 aborts the block.
        tick();
        bus.in_block  = c_C3_PT;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        k = 0;
        while (!busy && k < 20) begin tick(); k++; end
        bus.in_valid = 1'b0;
        k = 0;
        while (int'(round_o) != 7 && k < 30) begin tick(); k++; end
        check_int("midrst_reached_round7", int'(round_o), 7);
        #2 rst_n = 1'b0;
        #1;
        any = bus.in_ready | rk_req | bus.out_valid | busy | (|rk_addr) | (|round_o)
              | (|bus.out_block) | (|bus.sb_in);
        check_bit("midrst_async_zero", any, 1'b0);
        bus.in_valid = 1'b1;
        err = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.in_ready || busy) err++;
        end
        check_int("midrst_held_errs", err, 0);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        hs0          = hs_q.size();
        err = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.out_valid || busy) err++;
        end
        check_int("midrst_no_stale_errs", err, 0);
        check_int("midrst_no_stale_hs", hs_q.size() - hs0, 0);
        run_block(c_C3_PT, c_C3_CT, 2, 1'b0, "midrst_c3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
